mips_avalon_mem_responder: RTL



---
 rtl/mips_avalon_mem_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mips_avalon_mem_responder.sv
// Avalon-MM word memory responder for the CPU bench.
// Accepts one read or byte-enabled write at a time, stalls it through
// waitrequest for WAIT_CYCLES cycles, then acknowledges for exactly one cycle.
// Out-of-range, misaligned and read+write requests are still acknowledged
// (so the initiator never deadlocks), return zero, leave memory untouched
// and raise a sticky err flag.
module mips_avalon_mem_responder #(
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err,
    output logic [1:0]  state_out
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [7:0] CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;

    // Request captured at acceptance; only these values are used afterwards.
    logic [ADDR_BITS-1:0] idx_reg;
    logic [31:0]          wdata_reg;
    logic [3:0]           be_reg;
    logic                 op_rd_reg;
    logic                 op_wr_reg;
    logic                 op_bad_reg;
    logic                 err_reg;

    // Address decode of the live bus request.
    logic [31:0]          live_offset;
    logic [ADDR_BITS-1:0] live_idx;
    logic                 live_in_range;
    logic                 live_aligned;
    logic                 live_bad;
    logic                 accept;

    // Request being serviced: live bus while idle (zero-wait path), latched otherwise.
    logic [ADDR_BITS-1:0] cur_idx;
    logic [31:0]          cur_wdata;
    logic [3:0]           cur_be;
    logic                 cur_rd;
    logic                 cur_wr;
    logic                 cur_bad;
    logic                 enter_ack;
    logic                 mem_we;
    logic                 rd_load;

    assign live_offset   = address - BASE_ADDR;
    assign live_idx      = live_offset[ADDR_BITS+1:2];
    assign live_in_range = (live_offset[31:ADDR_BITS+2] == '0);
    assign live_aligned  = (address[1:0] == 2'b00);
    assign live_bad      = (read && write) || !live_in_range || !live_aligned;
    assign accept        = (state_reg == IDLE) && (read || write);

    assign cur_idx   = (state_reg == IDLE) ? live_idx   : idx_reg;
    assign cur_wdata = (state_reg == IDLE) ? writedata  : wdata_reg;
    assign cur_be    = (state_reg == IDLE) ? byteenable : be_reg;
    assign cur_rd    = (state_reg == IDLE) ? read       : op_rd_reg;
    assign cur_wr    = (state_reg == IDLE) ? write      : op_wr_reg;
    assign cur_bad   = (state_reg == IDLE) ? live_bad   : op_bad_reg;

    // Memory and readdata act on the edge that moves the FSM into ACK.
    // The rst term keeps a reset coinciding with that edge from writing memory.
    assign enter_ack = (state_next == ACK) && (state_reg != ACK);
    assign mem_we    = enter_ack && cur_wr && !cur_bad && !rst;
    assign rd_load   = enter_ack && (cur_rd || cur_bad);

    // State and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: IDLE -> WAIT (or straight to ACK) -> ACK -> IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 8'd0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request at acceptance and record any protocol/range error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg    <= '0;
            wdata_reg  <= 32'd0;
            be_reg     <= 4'd0;
            op_rd_reg  <= 1'b0;
            op_wr_reg  <= 1'b0;
            op_bad_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else if (accept) begin
            idx_reg    <= live_idx;
            wdata_reg  <= writedata;
            be_reg     <= byteenable;
            op_rd_reg  <= read;
            op_wr_reg  <= write;
            op_bad_reg <= live_bad;
            if (live_bad) begin
                err_reg <= 1'b1;
            end
        end
    end

    // One byte-wide RAM per lane so byteenable maps onto independent write enables.
    logic [3:0][7:0] rd_lanes;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rd_byte_reg;

            // Byte-lane write; the array itself is never reset.
            always_ff @(posedge clk) begin
                if (mem_we && cur_be[gi]) begin
                    mem_lane[cur_idx] <= cur_wdata[8*gi +: 8];
                end
            end

            // Registered read port; errored transfers return zero, writes leave it alone.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_byte_reg <= 8'd0;
                end else if (rd_load) begin
                    rd_byte_reg <= cur_bad ? 8'd0 : mem_lane[cur_idx];
                end
            end

            assign rd_lanes[gi] = rd_byte_reg;
        end
    endgenerate

    assign readdata    = rd_lanes;
    assign waitrequest = (state_reg != ACK);
    assign err         = err_reg;
    assign state_out   = state_reg;

endmodule
